// File: rtl/inst_rom_pack.sv
// ---------------------------------------------------------------------------
// inst_rom_pack
//   Loader-side instruction packer. Takes decoded MIPS fields over a
//   valid/ready handshake, packs them into a 32-bit R/I/J word, buffers the
//   words in a small FIFO and writes them to consecutive instruction-memory
//   word addresses through a back-pressured write port.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start, finish          open a load session / close it once the FIFO drains
//   fmt_in                 00=R, 01=I, 10=J, 11=illegal (accepted and dropped)
//   opcode_in .. target_in decoded instruction fields
//   in_valid, in_ready     field-set handshake
//   wr_en, wr_addr,
//   wr_data, wr_ready      instruction-memory write port (head of FIFO)
//   count                  words written this session
//   busy                   session active (RUN or DRAIN)
//   full_o                 last memory word written (sticky until start)
//   err_o                  illegal format seen (sticky until start)
// ---------------------------------------------------------------------------
module inst_rom_pack #(
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic [1:0]        fmt_in,
   input  logic [5:0]        opcode_in,
   input  logic [4:0]        r1_in,
   input  logic [4:0]        r2_in,
   input  logic [4:0]        m1_in,
   input  logic [4:0]        shamt_in,
   input  logic [5:0]        funct_in,
   input  logic [15:0]       s_in,
   input  logic [25:0]       target_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   input  logic              wr_ready,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              full_o,
   output logic              err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PW    = ADDR_W + 2;
   localparam int CAP_I = (1 << ADDR_W) - BASE_ADDR;
   localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] LAST = '1;
   localparam logic [PTR_W:0]    DEPTH_V = FIFO_DEPTH[PTR_W:0];

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, state_nx;

   logic [31:0]    mem [FIFO_DEPTH];
   logic [PTR_W:0] wptr, rptr, occ;
   logic           fifo_empty, fifo_full, room;
   logic           accept, vld_p0, pop, cap_hit, sess_start;
   logic [31:0]    word_p0;

   // Field packing; unused fields of a format are simply not referenced.
   function automatic logic [31:0] pack_word(
      input logic [1:0]  fmt,
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  sh,
      input logic [5:0]  fn,
      input logic [15:0] imm,
      input logic [25:0] tgt
   );
      logic [31:0] w;
      w = '0;
      case (fmt)
         2'b00:   w = {op, rs, rt, rd, sh, fn};
         2'b01:   w = {op, rs, rt, imm};
         2'b10:   w = {op, tgt};
         default: w = '0;
      endcase
      return w;
   endfunction

   assign occ        = wptr - rptr;
   assign fifo_empty = (occ == '0);
   assign fifo_full  = (occ == DEPTH_V);
   // Words already written plus words in flight must stay below capacity so
   // the pointer never has to wrap.
   assign room       = (PW'(count) + PW'(occ)) < PW'(CAP_I);

   assign busy       = (state == RUN) || (state == DRAIN);
   assign in_ready   = (state == RUN) && !fifo_full && room;
   assign wr_en      = busy && !fifo_empty;
   assign wr_data    = fifo_empty ? '0 : mem[rptr[PTR_W-1:0]];

   assign accept     = in_valid && in_ready;
   assign vld_p0     = accept && (fmt_in != 2'b11);
   assign pop        = wr_en && wr_ready;
   assign cap_hit    = pop && (wr_addr == LAST);
   assign sess_start = start && ((state == IDLE) || (state == DONE));

   assign word_p0 = pack_word(fmt_in, opcode_in, r1_in, r2_in, m1_in,
                              shamt_in, funct_in, s_in, target_in);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = RUN;
         RUN: begin
            if (cap_hit)     state_nx = DONE;
            else if (finish) state_nx = DRAIN;
         end
         DRAIN: if (cap_hit || fifo_empty) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   // ---- stage p0 -> FIFO: packed word registered on accept ----
   always_ff @(posedge clk) begin
      if (vld_p0) mem[wptr[PTR_W-1:0]] <= word_p0;
   end

   // ---- FIFO head -> memory write port ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         wptr    <= '0;
         rptr    <= '0;
         wr_addr <= BASE;
         count   <= '0;
         full_o  <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         state <= state_nx;
         if (sess_start) begin
            wptr    <= '0;
            rptr    <= '0;
            wr_addr <= BASE;
            count   <= '0;
            full_o  <= 1'b0;
            err_o   <= 1'b0;
         end else begin
            if (vld_p0) wptr <= wptr + 1'b1;
            if (pop) begin
               rptr  <= rptr + 1'b1;
               count <= count + 1'b1;
               // Hold the address on the last word instead of wrapping.
               if (wr_addr == LAST) full_o  <= 1'b1;
               else                 wr_addr <= wr_addr + 1'b1;
            end
            if (accept && (fmt_in == 2'b11)) err_o <= 1'b1;
         end
      end
   end

endmodule
